screen_scanner: RTL and testbench
=================================

Name: screen_scanner

Overview:
- Read-side master for the 8K-word screen region of the data memory map (512x256 pixels, 32 words per row, 1 bit per pixel).
- Walks the screen buffer in raster order and issues word reads.
- Serialises each word into a one-pixel-per-clock stream with line and frame framing and blanking intervals.
- Sits between the screen RAM read port and the display/test sink; the CPU remains the sole writer of the screen buffer.

Parameters:
- WORDS_PER_ROW, 32, screen words per pixel row; fixed at 32 in this design.
- ROWS, 256, pixel rows per frame.
- H_BLANK, 16, idle cycles after each row's active pixels; minimum 1.
- V_BLANK, 64, idle cycles after the last row's H_BLANK; minimum 1.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- enable  input  1  request continuous frame scanning
- rd_en  output  1  read strobe to screen RAM, one cycle per word
- rd_addr  output  13  screen word address = row*32 + word index
- rd_data  input  16  screen RAM data, valid the cycle after rd_en
- pixel  output  1  current pixel value, 1 = black
- pixel_valid  output  1  high on each of the 512 active pixel cycles of a row
- x  output  9  column of the current pixel, 0..511
- y  output  8  row of the current pixel, 0..255
- line_start  output  1  pulse coincident with x=0 of every row
- frame_start  output  1  pulse coincident with x=0, y=0
- frame_done  output  1  pulse on the last V_BLANK cycle
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all outputs 0; row, word and bit counters 0; shift register and prefetch buffer 0.
- States: IDLE, LOAD, ACTIVE, HBLANK, VBLANK.
- IDLE -> LOAD when enable=1 at a clk edge.
- LOAD lasts 2 cycles:
  - cycle 0: rd_en=1, rd_addr = row*32 + 0.
  - cycle 1: rd_data captured into the shift register.
  - Then -> ACTIVE.
- ACTIVE lasts 512 cycles:
  - pixel = shift register bit b, where b = x[3:0]. Bit 0 of each word is the leftmost pixel.
  - pixel_valid=1; x = word*16 + b; y = row.
  - At b=13 with word<31: rd_en=1, rd_addr = row*32 + word + 1.
  - At b=14: rd_data captured into the prefetch buffer.
  - At b=15: prefetch buffer moves to the shift register and word increments.
  - After x=511 -> HBLANK.
- HBLANK lasts H_BLANK cycles; pixel_valid=0 and pixel=0.
  - Then row<ROWS-1: row increments, -> LOAD.
  - Otherwise -> VBLANK.
- VBLANK lasts V_BLANK cycles; frame_done=1 on its last cycle.
  - Then row=0 and word=0.
  - enable=1 -> LOAD (next frame, no gap).
  - enable=0 -> IDLE.
- enable is sampled only in IDLE and at VBLANK exit. Deasserting it mid-frame finishes the current frame.
- Period per row = 2 + 512 + H_BLANK = 530 cycles at defaults.
- Period per frame = ROWS*530 + V_BLANK = 135744 cycles at defaults.
- Exactly 32 rd_en pulses per row and 8192 per frame. rd_addr covers 0..8191 in order with no repeats and no wrap inside a frame.
- rd_addr holds its last value when rd_en=0. rd_addr is don't-care to the sink when rd_en=0.
- rd_data is sampled only on the designated capture cycles; it is ignored at all other times.
- Reset mid-operation: immediate return to IDLE; no further rd_en pulses; counters cleared. The next frame starts at row 0.
- x, y, line_start and frame_start are 0 whenever pixel_valid=0.

Test Plan:
- Reset/idle: assert reset with enable=0 for 10 cycles -> all outputs 0, busy=0, no rd_en.
- Bit order: memory model with word 0 = 16'h0001, word 1 = 16'h8000, all else 0; enable=1 -> within frame, pixel=1 only at (x=0,y=0) and (x=31,y=0); frame_start once.
- Address sequence: model returns rd_data = rd_addr[12:0] zero-extended; record every rd_en -> 8192 pulses, addresses 0..8191 ascending. The first read of row 1 is 32, issued 530 cycles after the first read of row 0. Pixel stream reconstructs each address word.
- Timing: count cycles between frame_start pulses with enable held 1 -> 135744. line_start every 530 cycles. frame_done exactly 1 cycle before the following LOAD.
- enable drop: deassert enable at row 100 -> frame completes through VBLANK, frame_done pulses, then IDLE with busy=0 and no further rd_en.
- Reset mid-line: assert reset at row 5, x=200 -> outputs 0 immediately. Re-enable -> first rd_addr=0 and frame_start 3 cycles after enable sampled.

Source files
------------

// File: rtl/screen_scanner.sv
// Raster-order reader for the 1bpp screen buffer: fetches 16-bit words and
// serialises them into a framed one-pixel-per-clock stream with blanking.
//
// state  | meaning
// IDLE   | waiting for enable
// LOAD   | two-cycle fetch of the first word of a row into the shift register
// ACTIVE | 512 pixel cycles, next word prefetched while the current one shifts
// HBLANK | idle gap after each row
// VBLANK | idle gap after the last row, frame_done on its final cycle
module screen_scanner #(
  parameter int WORDS_PER_ROW = 32,
  parameter int ROWS          = 256,
  parameter int H_BLANK       = 16,
  parameter int V_BLANK       = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        rd_en,
  output logic [12:0] rd_addr,
  input  logic [15:0] rd_data,
  output logic        pixel,
  output logic        pixel_valid,
  output logic [8:0]  x,
  output logic [7:0]  y,
  output logic        line_start,
  output logic        frame_start,
  output logic        frame_done,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, LOAD, ACTIVE, HBLANK, VBLANK} state_t;

  localparam logic [15:0] HB_LOAD   = 16'(H_BLANK - 1);
  localparam logic [15:0] VB_LOAD   = 16'(V_BLANK - 1);
  localparam logic [7:0]  ROW_LAST  = 8'(ROWS - 1);
  localparam logic [4:0]  WORD_LAST = 5'(WORDS_PER_ROW - 1);

  state_t      state, state_nxt;
  logic [15:0] timer, timer_nxt;
  logic [7:0]  row, row_nxt;
  logic [4:0]  word, word_nxt;
  logic [3:0]  bitc, bitc_nxt;
  logic [15:0] shreg, shreg_nxt;
  logic [15:0] prefetch, prefetch_nxt;
  logic [12:0] addr_hold, addr_new;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      row       <= '0;
      word      <= '0;
      bitc      <= '0;
      shreg     <= '0;
      prefetch  <= '0;
      addr_hold <= '0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      row      <= row_nxt;
      word     <= word_nxt;
      bitc     <= bitc_nxt;
      shreg    <= shreg_nxt;
      prefetch <= prefetch_nxt;
      if (rd_en) addr_hold <= addr_new;
    end
  end

  // The address output holds its last issued value between strobes.
  assign rd_addr = rd_en ? addr_new : addr_hold;

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    row_nxt      = row;
    word_nxt     = word;
    bitc_nxt     = bitc;
    shreg_nxt    = shreg;
    prefetch_nxt = prefetch;
    rd_en        = 1'b0;
    addr_new     = {row, word};
    pixel        = 1'b0;
    pixel_valid  = 1'b0;
    x            = '0;
    y            = '0;
    line_start   = 1'b0;
    frame_start  = 1'b0;
    frame_done   = 1'b0;
    busy         = (state != IDLE);

    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = LOAD;
          timer_nxt = 16'd1;
        end
      end

      LOAD: begin
        if (timer != 16'd0) begin
          rd_en     = 1'b1;
          addr_new  = {row, 5'd0};
          timer_nxt = timer - 16'd1;
        end else begin
          shreg_nxt = rd_data;
          word_nxt  = '0;
          bitc_nxt  = '0;
          state_nxt = ACTIVE;
        end
      end

      ACTIVE: begin
        pixel_valid = 1'b1;
        pixel       = shreg[bitc];
        x           = {word, bitc};
        y           = row;
        line_start  = (word == 5'd0) && (bitc == 4'd0);
        frame_start = line_start && (row == 8'd0);
        bitc_nxt    = bitc + 4'd1;
        if (bitc == 4'd13 && word != WORD_LAST) begin
          rd_en    = 1'b1;
          addr_new = {row, word + 5'd1};
        end
        if (bitc == 4'd14) prefetch_nxt = rd_data;
        if (bitc == 4'd15) begin
          shreg_nxt = prefetch;
          word_nxt  = word + 5'd1;
          if (word == WORD_LAST) begin
            state_nxt = HBLANK;
            timer_nxt = HB_LOAD;
          end
        end
      end

      HBLANK: begin
        if (timer == 16'd0) begin
          if (row != ROW_LAST) begin
            row_nxt   = row + 8'd1;
            state_nxt = LOAD;
            timer_nxt = 16'd1;
          end else begin
            state_nxt = VBLANK;
            timer_nxt = VB_LOAD;
          end
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end

      VBLANK: begin
        if (timer == 16'd0) begin
          frame_done = 1'b1;
          row_nxt    = '0;
          word_nxt   = '0;
          if (enable) begin
            state_nxt = LOAD;
            timer_nxt = 16'd1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_screen_scanner.sv
// Bench for screen_scanner: a frame-position model derived from row/frame
// periods predicts every output each cycle; memory model answers reads.
module tb_screen_scanner;
  localparam int ROWS  = 8;
  localparam int HB    = 5;
  localparam int VB    = 7;
  localparam int ROW_P = 2 + 512 + HB;
  localparam int FRAME = ROWS * ROW_P + VB;
  localparam int NREAD = ROWS * 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] rd_data = 16'h0;
  logic        rd_en, pixel, pixel_valid, line_start, frame_start, frame_done, busy;
  logic [12:0] rd_addr;
  logic [8:0]  x;
  logic [7:0]  y;

  screen_scanner #(.WORDS_PER_ROW(32), .ROWS(ROWS), .H_BLANK(HB), .V_BLANK(VB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .pixel(pixel), .pixel_valid(pixel_valid), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start), .frame_done(frame_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Screen RAM: data valid in the cycle after the strobe, garbage otherwise.
  logic [15:0] mem [0:8191];
  logic        pend_en = 1'b0;
  logic [12:0] pend_a = '0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rd_data = pend_en ? mem[pend_a] : 16'($urandom);
    end
  end

  // Reference: the scanner is either idle or at cycle m_c of a frame.
  bit          m_run = 1'b0;
  int          m_c = 0;
  logic [12:0] m_last = '0;

  function automatic logic [36:0] model_out();
    logic be = 1'b0, re = 1'b0, pe = 1'b0, pv = 1'b0, ls = 1'b0, fs = 1'b0, fd = 1'b0;
    logic [12:0] a = m_last;
    logic [8:0]  xe = '0;
    logic [7:0]  ye = '0;
    int row, r, xx, w;
    if (m_run) begin
      be  = 1'b1;
      row = m_c / ROW_P;
      r   = m_c % ROW_P;
      if (row < ROWS) begin
        if (r == 0) begin
          re = 1'b1;
          a  = 13'(row * 32);
        end else if (r >= 2 && r < 514) begin
          xx = r - 2;
          w  = xx / 16;
          pv = 1'b1;
          xe = 9'(xx);
          ye = 8'(row);
          pe = mem[row * 32 + w][xx % 16];
          ls = (xx == 0);
          fs = (xx == 0) && (row == 0);
          if (xx % 16 == 13 && w < 31) begin
            re = 1'b1;
            a  = 13'(row * 32 + w + 1);
          end
        end
      end else begin
        fd = (m_c == FRAME - 1);
      end
    end
    return {be, re, a, pe, pv, xe, ye, ls, fs, fd};
  endfunction

  logic [36:0] got_vec;
  assign got_vec = {busy, rd_en, rd_addr, pixel, pixel_valid, x, y, line_start, frame_start, frame_done};

  int cyc = 0;
  int fs_cnt, fs_prev, fs_last, ls_cnt, ls1, ls2, fd_cnt, rd_cnt;
  logic [12:0] rd_addr_q[$];
  int          rd_cyc_q[$];
  logic [16:0] ones_q[$];

  task automatic clear_mon();
    fs_cnt = 0; fs_prev = 0; fs_last = 0; ls_cnt = 0; ls1 = 0; ls2 = 0;
    fd_cnt = 0; rd_cnt = 0;
    rd_addr_q.delete(); rd_cyc_q.delete(); ones_q.delete();
  endtask

  task automatic compare_now(input string tag);
    logic [36:0] e;
    e = model_out();
    chk(tag, {27'b0, got_vec}, {27'b0, e});
    m_last = e[34:22];
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_run = 1'b0;
      m_last = '0;
    end else if (!m_run) begin
      if (enable) begin
        m_run = 1'b1;
        m_c = 0;
      end
    end else if (m_c == FRAME - 1) begin
      if (enable) m_c = 0;
      else m_run = 1'b0;
    end else begin
      m_c++;
    end
    @(negedge clk);
    compare_now("outs");
    if (frame_start) begin fs_cnt++; fs_prev = fs_last; fs_last = cyc; end
    if (line_start) begin
      ls_cnt++;
      if (ls_cnt == 1) ls1 = cyc;
      if (ls_cnt == 2) ls2 = cyc;
    end
    if (frame_done) fd_cnt++;
    if (rd_en) begin rd_cnt++; rd_addr_q.push_back(rd_addr); rd_cyc_q.push_back(cyc); end
    if (pixel_valid && pixel) ones_q.push_back({y, x});
    pend_en = rd_en;
    pend_a  = rd_addr;
    cyc++;
  endtask

  task automatic reset_now();
    reset = 1'b1;
    #1;
    m_run = 1'b0;
    m_last = '0;
    pend_en = 1'b0;
    compare_now("rst_async");
  endtask

  initial begin
    int k, fd0, first_rd, first_fs;
    logic [12:0] first_addr;
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0;
    clear_mon();

    // Reset held with enable low
    for (int i = 0; i < 10; i++) step();
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_rd_cnt", 64'(rd_cnt), 64'd0);

    // Bit order: single frame requested by a one-cycle enable
    mem[0] = 16'h0001;
    mem[1] = 16'h8000;
    reset = 1'b0;
    clear_mon();
    enable = 1'b1;
    step();
    enable = 1'b0;
    k = 0;
    while (fd_cnt < 1 && k < FRAME + 20) begin step(); k++; end
    chk("bo_fd_seen", 64'(fd_cnt), 64'd1);
    step(); step();
    chk("bo_idle_busy", {63'b0, busy}, 64'd0);
    chk("bo_ones", 64'(ones_q.size()), 64'd2);
    if (ones_q.size() >= 2) begin
      chk("bo_p0", {47'b0, ones_q[0]}, {47'b0, 8'd0, 9'd0});
      chk("bo_p1", {47'b0, ones_q[1]}, {47'b0, 8'd0, 9'd31});
    end
    chk("bo_fs_cnt", 64'(fs_cnt), 64'd1);

    // Address sequence and timing with enable held
    for (int i = 0; i < 8192; i++) mem[i] = 16'(i);
    clear_mon();
    enable = 1'b1;
    k = 0;
    while (fd_cnt < 1 && k < FRAME + 20) begin step(); k++; end
    chk("as_rd_cnt", 64'(rd_cnt), 64'(NREAD));
    for (int i = 0; i < rd_addr_q.size() && i < NREAD; i++)
      chk("as_addr_seq", {51'b0, rd_addr_q[i]}, 64'(i));
    if (rd_cyc_q.size() > 32) chk("as_row1_gap", 64'(rd_cyc_q[32] - rd_cyc_q[0]), 64'(ROW_P));
    chk("as_ls_gap", 64'(ls2 - ls1), 64'(ROW_P));
    step();
    chk("fd_to_load_rd", {63'b0, rd_en}, 64'd1);
    chk("fd_to_load_addr", {51'b0, rd_addr}, 64'd0);
    k = 0;
    while (fs_cnt < 2 && k < FRAME + 20) begin step(); k++; end
    chk("frame_period", 64'(fs_last - fs_prev), 64'(FRAME));

    // Enable dropped at row 3: frame completes, then idle
    k = 0;
    while (!(pixel_valid && y == 8'd3) && k < FRAME + 20) begin step(); k++; end
    chk("ed_row3_seen", {63'b0, pixel_valid}, 64'd1);
    enable = 1'b0;
    fd0 = fd_cnt;
    k = 0;
    while (fd_cnt == fd0 && k < FRAME + 20) begin step(); k++; end
    chk("ed_fd_once", 64'(fd_cnt - fd0), 64'd1);
    rd_cnt = 0;
    for (int i = 0; i < 40; i++) step();
    chk("ed_busy", {63'b0, busy}, 64'd0);
    chk("ed_no_rd", 64'(rd_cnt), 64'd0);

    // Reset mid-line at row 5, x=200
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    enable = 1'b1;
    k = 0;
    while (!(pixel_valid && y == 8'd5 && x == 9'd200) && k < 2 * FRAME) begin step(); k++; end
    chk("mr_pos_seen", {63'b0, pixel_valid}, 64'd1);
    reset_now();
    step(); step();
    reset = 1'b0;
    enable = 1'b0;
    rd_cnt = 0;
    for (int i = 0; i < 3; i++) step();
    chk("mr_no_rd", 64'(rd_cnt), 64'd0);
    enable = 1'b1;
    first_rd = -1; first_fs = -1; first_addr = '1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (rd_en && first_rd < 0) begin first_rd = i; first_addr = rd_addr; end
      if (frame_start && first_fs < 0) first_fs = i;
    end
    chk("mr_first_rd", 64'(first_rd), 64'd1);
    chk("mr_first_addr", {51'b0, first_addr}, 64'd0);
    chk("mr_fs_latency", 64'(first_fs), 64'd3);

    // Random enable toggles and reset pulses
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      if ($urandom_range(0, 1999) == 0) begin
        reset_now();
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
